// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the run/halt/step sequencer: state encoding and the
// speed-select to divider-shift rule.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } run_state_t;

    // Each speed step divides the period by four.
    function automatic logic [2:0] speed_shift(input logic [1:0] speed);
        return {speed, 1'b0};
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stable-level counter and a
// one-cycle press pulse on each debounced high-to-low transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iKEY_N,
    output logic oPRESS
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_p0;
    logic          key_p1;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            oPRESS <= 1'b0;
        end else begin
            key_p0 <= iKEY_N;
            key_p1 <= key_p0;
            oPRESS <= 1'b0;
            // Any sample agreeing with the debounced level restarts the count.
            if (key_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= key_p1;
                cnt    <= '0;
                oPRESS <= ~key_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer producing a one-cycle CPU clock enable on the
// fabric clock, driven by two debounced pushbuttons and the core's halt request.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV     = 25000000,
    parameter int          DIV_WIDTH       = 32,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iKEY_RUN_N,
    input  logic                 iKEY_STEP_N,
    input  logic [1:0]           iSPEED,
    input  logic                 iHALT_REQ,
    output logic                 oCPU_CE,
    output logic                 oCPU_CLK,
    output logic                 oRUNNING,
    output logic [1:0]           oSTATE,
    output logic [CNT_WIDTH-1:0] oCE_COUNT
);

    localparam logic [DIV_WIDTH-1:0] DIV_FULL = DIV_WIDTH'(DEFAULT_DIV);

    logic                 run_press;
    logic                 step_press;
    run_state_t           state;
    run_state_t           state_nxt;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_nxt;
    logic [DIV_WIDTH-1:0] period;
    logic [DIV_WIDTH-1:0] period_last;
    logic                 ce_nxt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iKEY_N (iKEY_RUN_N),
        .oPRESS (run_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iKEY_N (iKEY_STEP_N),
        .oPRESS (step_press)
    );

    // A shifted-out period collapses to one enable per cycle.
    always_comb begin
        period = DIV_FULL >> speed_shift(iSPEED);
        if (period == '0) begin
            period = DIV_WIDTH'(1);
        end
        period_last = period - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_q;
        ce_nxt    = 1'b0;
        case (state)
            ST_HALT: begin
                if (run_press && !iHALT_REQ) begin
                    state_nxt = ST_RUN;
                    div_nxt   = '0;
                end else if (step_press) begin
                    state_nxt = ST_STEP;
                    ce_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                // Leaving RUN suppresses the enable that might fire this cycle.
                if (iHALT_REQ || run_press) begin
                    state_nxt = ST_HALT;
                end else if (div_q >= period_last) begin
                    ce_nxt  = 1'b1;
                    div_nxt = '0;
                end else begin
                    div_nxt = div_q + 1'b1;
                end
            end
            ST_STEP: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state     <= ST_HALT;
            div_q     <= '0;
            oCPU_CE   <= 1'b0;
            oCPU_CLK  <= 1'b1;
            oCE_COUNT <= '0;
            oRUNNING  <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_q    <= div_nxt;
            oCPU_CE  <= ce_nxt;
            oRUNNING <= (state_nxt == ST_RUN);
            if (ce_nxt) begin
                oCPU_CLK  <= ~oCPU_CLK;
                oCE_COUNT <= oCE_COUNT + 1'b1;
            end
        end
    end

    assign oSTATE = state;

endmodule
